// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for the ATMega32A emulator core.
// Holds the program counter, reads program memory over a request/valid
// handshake and presents each word to the decoder with its part2 flag.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  S_FETCH   | strobe pmem_rd for one cycle at pc
//  S_WAIT    | read outstanding, waiting for pmem_valid
//  S_ISSUE   | word presented on instr_*, waiting for exec_ready
//  S_DISCARD | redirected with a read outstanding; drop the stale data
module fetch_sequencer #(
    parameter int PC_WIDTH = 14
) (
    input  logic                clk,
    input  logic                reset,
    output logic                pmem_rd,
    output logic [PC_WIDTH-1:0] pmem_addr,
    input  logic [15:0]         pmem_data,
    input  logic                pmem_valid,
    output logic [15:0]         instr_word,
    output logic                part2,
    output logic [PC_WIDTH-1:0] instr_addr,
    output logic                instr_valid,
    input  logic                exec_ready,
    input  logic                pc_load,
    input  logic [PC_WIDTH-1:0] pc_target
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_ISSUE   = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                need_part2_q, need_part2_d;
    logic [15:0]         word_q, word_d;
    logic [PC_WIDTH-1:0] addr_q, addr_d;
    logic                part2_q, part2_d;
    logic                valid_q, valid_d;
    // Keeps pmem_rd low in the reset cycle itself; the first strobe follows
    // the first edge after reset release.
    logic                fetch_en_q;

    // CALL, JMP, LDS and STS carry a second opcode word.
    function automatic logic is_two_word(input logic [15:0] w);
        logic hit;
        hit = 1'b0;
        casez (w)
            16'b1001_010?_????_11??: hit = 1'b1;
            16'b1001_000?_????_0000: hit = 1'b1;
            16'b1001_001?_????_0000: hit = 1'b1;
            default:                 hit = 1'b0;
        endcase
        return hit;
    endfunction

    assign pmem_rd     = (state_q == S_FETCH) && fetch_en_q;
    assign pmem_addr   = pc_q;
    assign instr_word  = word_q;
    assign part2       = part2_q;
    assign instr_addr  = addr_q;
    assign instr_valid = valid_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= '0;
            need_part2_q <= 1'b0;
            word_q       <= 16'h0000;
            addr_q       <= '0;
            part2_q      <= 1'b0;
            valid_q      <= 1'b0;
            fetch_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            need_part2_q <= need_part2_d;
            word_q       <= word_d;
            addr_q       <= addr_d;
            part2_q      <= part2_d;
            valid_q      <= valid_d;
            fetch_en_q   <= 1'b1;
        end
    end

    // Next-state logic; a redirect overrides whatever the state decided.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        need_part2_d = need_part2_q;
        word_d       = word_q;
        addr_d       = addr_q;
        part2_d      = part2_q;
        valid_d      = valid_q;

        case (state_q)
            S_FETCH: begin
                if (fetch_en_q) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pmem_valid) begin
                    word_d  = pmem_data;
                    addr_d  = pc_q;
                    part2_d = need_part2_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (exec_ready) begin
                    valid_d      = 1'b0;
                    state_d      = S_FETCH;
                    // A second word is never itself classified.
                    need_part2_d = !part2_q && is_two_word(word_q);
                end
            end
            S_DISCARD: begin
                if (pmem_valid) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (pc_load) begin
            pc_d = pc_target;
            if (state_q != S_DISCARD) begin
                need_part2_d = 1'b0;
                valid_d      = 1'b0;
                part2_d      = 1'b0;
                if (((state_q == S_WAIT) || pmem_rd) && !pmem_valid) begin
                    state_d = S_DISCARD;
                end else begin
                    state_d = S_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a variable-latency memory model.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        pmem_rd;
    logic [13:0] pmem_addr;
    logic [15:0] pmem_data;
    logic        pmem_valid;
    logic [15:0] instr_word;
    logic        part2;
    logic [13:0] instr_addr;
    logic        instr_valid;
    logic        exec_ready;
    logic        pc_load;
    logic [13:0] pc_target;

    int          checks;
    int          errors;
    int          cyc;
    int          lat;
    int          mem_cnt;
    logic [13:0] mem_rd_addr;
    logic [15:0] mem [0:16383];

    fetch_sequencer #(.PC_WIDTH(14)) dut (
        .clk         (clk),
        .reset       (reset),
        .pmem_rd     (pmem_rd),
        .pmem_addr   (pmem_addr),
        .pmem_data   (pmem_data),
        .pmem_valid  (pmem_valid),
        .instr_word  (instr_word),
        .part2       (part2),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .exec_ready  (exec_ready),
        .pc_load     (pc_load),
        .pc_target   (pc_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: one read outstanding, data returned lat cycles after the strobe.
    initial begin
        pmem_valid  = 1'b0;
        pmem_data   = 16'h0000;
        mem_cnt     = 0;
        mem_rd_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            pmem_valid = 1'b0;
            if (reset) begin
                mem_cnt = 0;
            end else begin
                if (mem_cnt > 0) begin
                    mem_cnt = mem_cnt - 1;
                    if (mem_cnt == 0) begin
                        pmem_valid = 1'b1;
                        pmem_data  = mem[mem_rd_addr];
                    end
                end
                if (pmem_rd) begin
                    mem_cnt     = lat;
                    mem_rd_addr = pmem_addr;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rd();
        for (int i = 0; i < 50; i++) begin
            if (pmem_rd) break;
            @(negedge clk);
        end
        chk("rd_seen", {31'd0, pmem_rd}, 32'd1);
    endtask

    // Waits for the strobe at a, then for the presented word; checks all fields and latency.
    task automatic fetch_check(input logic [13:0] a, input logic [15:0] w, input logic p,
                               output int rd_cyc);
        wait_rd();
        chk("fetch_addr", {18'd0, pmem_addr}, {18'd0, a});
        rd_cyc = cyc;
        for (int i = 0; i < 50; i++) begin
            if (instr_valid) break;
            @(negedge clk);
        end
        chk("valid_seen", {31'd0, instr_valid}, 32'd1);
        chk("valid_latency", cyc - rd_cyc, lat + 1);
        chk("instr_word", {16'd0, instr_word}, {16'd0, w});
        chk("instr_addr", {18'd0, instr_addr}, {18'd0, a});
        chk("part2", {31'd0, part2}, {31'd0, p});
    endtask

    // Pulses pc_load for one edge; call from the negedge where the core is in ISSUE.
    task automatic redirect(input logic [13:0] t);
        pc_load   = 1'b1;
        pc_target = t;
        @(negedge clk);
        pc_load   = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_pmem_rd", {31'd0, pmem_rd}, 32'd0);
        chk("rst_pmem_addr", {18'd0, pmem_addr}, 32'd0);
        chk("rst_instr_word", {16'd0, instr_word}, 32'd0);
        chk("rst_part2", {31'd0, part2}, 32'd0);
        chk("rst_instr_addr", {18'd0, instr_addr}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    endtask

    logic [13:0] g_base   [4] = '{14'h010, 14'h020, 14'h030, 14'h040};
    logic [15:0] g_first  [4] = '{16'h940E, 16'h9100, 16'h9200, 16'h940C};
    logic [15:0] g_second [4] = '{16'h1234, 16'hABCD, 16'h5678, 16'h940E};
    logic [15:0] g_third  [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    initial begin
        int r0, r1, rc;
        logic        bad;
        logic [15:0] snap_word;
        logic [13:0] snap_addr;

        checks = 0; errors = 0; cyc = 0; lat = 1;
        reset = 1'b1; exec_ready = 1'b1; pc_load = 1'b0; pc_target = '0;
        for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
        mem[0]       = 16'h0C01;
        mem[1]       = 16'h0000;
        for (int g = 0; g < 4; g++) begin
            mem[g_base[g]]         = g_first[g];
            mem[g_base[g] + 14'd1] = g_second[g];
            mem[g_base[g] + 14'd2] = g_third[g];
        end
        mem[14'h050] = 16'h2345;
        mem[14'h051] = 16'hDEAD;
        mem[14'h100] = 16'h940E;
        mem[14'h3FFF] = 16'h5555;

        repeat (3) @(negedge clk);
        chk_reset_outputs();
        reset = 1'b0;
        @(negedge clk);
        chk("first_rd", {31'd0, pmem_rd}, 32'd1);

        // Basic stream, latency 1, three cycles per word.
        fetch_check(14'h000, 16'h0C01, 1'b0, r0);
        fetch_check(14'h001, 16'h0000, 1'b0, r1);
        chk("throughput", r1 - r0, 3);

        // Two-word opcodes: the second word carries part2, the third does not.
        for (int g = 0; g < 4; g++) begin
            redirect(g_base[g]);
            fetch_check(g_base[g], g_first[g], 1'b0, rc);
            fetch_check(g_base[g] + 14'd1, g_second[g], 1'b1, rc);
            fetch_check(g_base[g] + 14'd2, g_third[g], 1'b0, rc);
        end

        // Stall in ISSUE: everything holds and no read is issued.
        redirect(14'h050);
        exec_ready = 1'b0;
        fetch_check(14'h050, 16'h2345, 1'b0, rc);
        snap_word = instr_word;
        snap_addr = instr_addr;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (!instr_valid || pmem_rd || part2 || instr_word != snap_word || instr_addr != snap_addr)
                bad = 1'b1;
        end
        chk("stall_stable", {31'd0, bad}, 32'd0);
        lat = 4;
        exec_ready = 1'b1;
        @(negedge clk);
        chk("rd_after_accept", {31'd0, pmem_rd}, 32'd1);
        chk("rd_after_accept_addr", {18'd0, pmem_addr}, 32'h051);
        rc = cyc;

        // Redirect with a slow read outstanding: stale data must be dropped.
        @(negedge clk);
        @(negedge clk);
        redirect(14'h100);
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (instr_valid) bad = 1'b1;
            if (pmem_rd) break;
            @(negedge clk);
        end
        chk("stale_not_presented", {31'd0, bad}, 32'd0);
        chk("redirect_addr", {18'd0, pmem_addr}, 32'h100);
        chk("redirect_delay", cyc - rc, 5);
        fetch_check(14'h100, 16'h940E, 1'b0, rc);

        // Redirect right after a CALL first word clears the pending part2; pc wraps.
        lat = 1;
        redirect(14'h3FFF);
        fetch_check(14'h3FFF, 16'h5555, 1'b0, rc);
        fetch_check(14'h000, 16'h0C01, 1'b0, rc);

        // Reset pulsed while a read is outstanding.
        wait_rd();
        chk("pre_reset_addr", {18'd0, pmem_addr}, 32'h001);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_rd", {31'd0, pmem_rd}, 32'd1);
        chk("post_reset_addr", {18'd0, pmem_addr}, 32'd0);
        fetch_check(14'h000, 16'h0C01, 1'b0, rc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the ATMega32A emulator core. It holds the program counter and reads 16-bit words from program memory over a request/valid handshake. Each word is presented, with the matching `part2` flag, to the instruction decoder and execute stage over a valid/ready handshake. It detects the two-word opcodes (CALL, JMP, LDS, STS) so their second word reaches the decoder with `part2=1`, and it applies PC redirects from the execute stage.

## Interface
- `PC_WIDTH`, default 14: program-counter width in words; 16K words covers 32 KB flash.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `pmem_rd`  out  1  one-cycle read strobe to program memory.
- `pmem_addr`  out  PC_WIDTH  word address of the read; valid while `pmem_rd`=1.
- `pmem_data`  in  16  read data; sampled only when `pmem_valid`=1.
- `pmem_valid`  in  1  read data valid, one cycle, any latency ≥1 after `pmem_rd`.
- `instr_word`  out  16  word presented to the decoder `instruction` input.
- `part2`  out  1  `instr_word` is the second word of a two-word instruction.
- `instr_addr`  out  PC_WIDTH  word address of `instr_word`.
- `instr_valid`  out  1  `instr_word`/`part2`/`instr_addr` valid.
- `exec_ready`  in  1  execute stage accepts the presented word this cycle.
- `pc_load`  in  1  redirect request; highest priority.
- `pc_target`  in  PC_WIDTH  redirect word address.

## Operation
- States: FETCH, WAIT, ISSUE, DISCARD. Internal regs: `pc`, `need_part2`.
- FETCH: drive `pmem_rd`=1 and `pmem_addr`=`pc` for exactly one cycle, then go to WAIT.
- WAIT: on `pmem_valid`, latch `pmem_data`→`instr_word`, `pc`→`instr_addr`, `need_part2`→`part2`. Set `instr_valid`=1, `pc`←`pc`+1 (mod 2^PC_WIDTH; 0x3FFF wraps to 0), go to ISSUE.
- ISSUE: hold all outputs stable while `exec_ready`=0. On `exec_ready`=1: clear `instr_valid`, go to FETCH, update `need_part2`:
  - `need_part2`←1 when `part2`=0 and `instr_word` matches one of:
    - CALL `1001_010x_xxxx_111x`
    - JMP `1001_010x_xxxx_110x`
    - LDS `1001_000x_xxxx_0000`
    - STS `1001_001x_xxxx_0000`
  - Otherwise `need_part2`←0. A second word is never itself classified.
- `pc_load`=1 (any state) sets `pc`←`pc_target`, `need_part2`←0, `instr_valid`←0, `part2`←0.
  - Next state is DISCARD if the current state is WAIT, or FETCH with `pmem_rd` asserted this cycle, and no `pmem_valid` occurs this cycle. Otherwise the next state is FETCH.
- DISCARD: wait for `pmem_valid`, drop the data, go to FETCH. A further `pc_load` in DISCARD only updates `pc`.
- `pc_load` and `exec_ready` in the same ISSUE cycle: the word is consumed and the redirect wins for the next fetch.
- `pc_load` and `pmem_valid` in the same WAIT cycle: the data is dropped and the next state is FETCH.
- `pmem_valid` outside WAIT/DISCARD is ignored.

## Timing
- Reset (async) values:
  - State FETCH; `pc`=0, `need_part2`=0.
  - `pmem_rd`=0, `pmem_addr`=0.
  - `instr_word`=0x0000, `part2`=0, `instr_addr`=0, `instr_valid`=0.
- First rising edge after `reset` falls: `pmem_rd`=1, `pmem_addr`=0 in that cycle.
- All outputs are registered; `pmem_rd` is decoded from the FETCH state register.
- Memory latency L cycles: `instr_valid` rises L+1 cycles after `pmem_rd`. With L=1 and `exec_ready` tied high, throughput is one word per 3 cycles.
- Redirect: `pmem_rd` at `pc_target` appears on the second edge after `pc_load` if nothing is outstanding. Otherwise it appears one cycle after the discarded `pmem_valid`.
- Reset asserted mid-operation drops any outstanding read. A `pmem_valid` arriving after reset release and before the first FETCH completes is ignored.

## Test plan
- Reset release, memory latency 1, `exec_ready`=1, words 0x0C01, 0x0000 at 0,1 -> `pmem_addr` 0,1 with strobes 3 cycles apart. Presented: 0x0C01 `instr_addr`=0 `part2`=0, then 0x0000 `instr_addr`=1 `part2`=0.
- CALL 0x940E at 0x0010, 0x1234 at 0x0011 -> 0x940E `part2`=0, then 0x1234 `part2`=1, then the word at 0x0012 with `part2`=0. Repeat for LDS 0x9100, STS 0x9200, JMP 0x940C.
- `exec_ready` low for 5 cycles in ISSUE -> all outputs stable, no `pmem_rd`. Accept on cycle 6 -> `pmem_rd` on the next cycle.
- Memory latency 4; `pc_load`=1, `pc_target`=0x0100 two cycles after `pmem_rd` -> stale `pmem_valid` discarded, next `pmem_addr`=0x0100, no `instr_valid` for the stale word.
- `pc_load` with `need_part2`=1 after a CALL first word -> word at the target presented with `part2`=0.
- `pc`=0x3FFF -> next fetch address 0x0000. Reset pulsed during WAIT -> all outputs at reset values immediately, `pmem_rd` at address 0 after release.
